// File: rtl/stoch_signed_pool_pkg.sv
// Shared types and helpers for the signed stochastic pooling layer.
package stoch_pool_pkg;

    typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_t;

    // Floor-division output size of a padded, strided window sweep.
    function automatic int out_dim(input int im, input int pad, input int k, input int stride);
        return (im + 2 * pad - k) / stride + 1;
    endfunction

    // Symmetric saturating add: the most negative two's-complement code is never produced.
    function automatic int sat_add(input int cnt, input int delta, input int width);
        int lim;
        int s;
        lim = (1 << (width - 1)) - 1;
        s   = cnt + delta;
        if (s > lim)
            s = lim;
        else if (s < -lim)
            s = -lim;
        return s;
    endfunction

endpackage

// File: rtl/stoch_signed_pool_if.sv
// Bitstream bus of the pooling layer: qualified input map in, registered pooled map out.
interface stoch_signed_pool_if
    import stoch_pool_pkg::*;
#(
    parameter int IM_HEIGHT  = 12,
    parameter int IM_WIDTH   = 12,
    parameter int CHANNELS   = 3,
    parameter int OUT_HEIGHT = out_dim(12, 1, 3, 1),
    parameter int OUT_WIDTH  = out_dim(12, 1, 3, 1)
);
    logic                                                en;
    logic                                                restart;
    logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0]    x_p;
    logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0]    x_m;
    logic [OUT_HEIGHT-1:0][OUT_WIDTH-1:0][CHANNELS-1:0]  y_p;
    logic [OUT_HEIGHT-1:0][OUT_WIDTH-1:0][CHANNELS-1:0]  y_m;
    logic                                                y_valid;

    modport master (output en, restart, x_p, x_m, input y_p, y_m, y_valid);
    modport slave  (input en, restart, x_p, x_m, output y_p, y_m, y_valid);
endinterface

// File: rtl/stoch_signed_window_max.sv
// One pooling window in max mode: per-tap signed running estimators and an argmax
// that picks which tap's (p, m) pair is forwarded this cycle.
module stoch_signed_window_max
    import stoch_pool_pkg::*;
#(
    parameter int NUM_INPUTS = 9,
    parameter int COUNT_W    = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  en,
    input  logic                  restart,
    input  logic [NUM_INPUTS-1:0] as_p,
    input  logic [NUM_INPUTS-1:0] as_m,
    input  logic [NUM_INPUTS-1:0] pad_mask,
    output logic                  y_p,
    output logic                  y_m
);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic signed [COUNT_W-1:0] cnt_q   [NUM_INPUTS];
    logic signed [COUNT_W-1:0] cnt_d   [NUM_INPUTS];
    logic signed [COUNT_W-1:0] cnt_cur [NUM_INPUTS];
    logic signed [COUNT_W-1:0] best;
    logic [IDX_W-1:0]          sel_idx;

    // Argmax on pre-update estimators (strict > keeps the lowest tap on ties), then update.
    always_comb begin
        for (int t = 0; t < NUM_INPUTS; t++) begin
            cnt_cur[t] = restart ? '0 : cnt_q[t];
        end
        best    = cnt_cur[0];
        sel_idx = '0;
        for (int t = 1; t < NUM_INPUTS; t++) begin
            if (cnt_cur[t] > best) begin
                best    = cnt_cur[t];
                sel_idx = IDX_W'(t);
            end
        end
        y_p = as_p[sel_idx];
        y_m = as_m[sel_idx];
        for (int t = 0; t < NUM_INPUTS; t++) begin
            cnt_d[t] = cnt_cur[t];
            if (en && !pad_mask[t])
                cnt_d[t] = COUNT_W'(sat_add(int'(cnt_cur[t]),
                                            int'(as_p[t]) - int'(as_m[t]), COUNT_W));
        end
    end

    // Estimator registers; padding taps are never written and so remain zero.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int t = 0; t < NUM_INPUTS; t++) cnt_q[t] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/stoch_signed_pool.sv
// Signed stochastic pooling over a full H x W x C bitstream map, max or average mode,
// with a single registered output stage.
module stoch_signed_pool
    import stoch_pool_pkg::*;
#(
    parameter int         IM_HEIGHT = 12,
    parameter int         IM_WIDTH  = 12,
    parameter int         CHANNELS  = 3,
    parameter int         KERNEL_H  = 3,
    parameter int         KERNEL_W  = 3,
    parameter int         PAD_H     = 1,
    parameter int         PAD_W     = 1,
    parameter int         STRIDE_H  = 1,
    parameter int         STRIDE_W  = 1,
    parameter pool_mode_t MODE      = POOL_MAX,
    parameter int         COUNT_W   = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    stoch_signed_pool_if.slave bus
);
    localparam int OUT_HEIGHT = out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H);
    localparam int OUT_WIDTH  = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W);
    localparam int K          = KERNEL_H * KERNEL_W;
    localparam int SEL_W      = (K > 1) ? $clog2(K) : 1;

    typedef logic [OUT_HEIGHT-1:0][OUT_WIDTH-1:0][CHANNELS-1:0] omap_t;

    logic [OUT_HEIGHT-1:0][OUT_WIDTH-1:0][CHANNELS-1:0][K-1:0] tap_p, tap_m;
    omap_t win_p, win_m;
    omap_t y_p_d, y_p_q, y_m_d, y_m_q;
    logic  y_valid_d, y_valid_q;

    // True when tap t of output (oh, ow) lands inside the image rather than in padding.
    function automatic logic tap_in_img(input int oh, input int ow, input int t);
        int ih;
        int iw;
        ih = oh * STRIDE_H - PAD_H + t / KERNEL_W;
        iw = ow * STRIDE_W - PAD_W + t % KERNEL_W;
        return (ih >= 0) && (ih < IM_HEIGHT) && (iw >= 0) && (iw < IM_WIDTH);
    endfunction

    // Static window wiring: every tap is either an input bit or a constant-zero pad.
    for (genvar oh = 0; oh < OUT_HEIGHT; oh++) begin : g_oh
        for (genvar ow = 0; ow < OUT_WIDTH; ow++) begin : g_ow
            for (genvar c = 0; c < CHANNELS; c++) begin : g_c
                for (genvar t = 0; t < K; t++) begin : g_tap
                    localparam int IH = oh * STRIDE_H - PAD_H + t / KERNEL_W;
                    localparam int IW = ow * STRIDE_W - PAD_W + t % KERNEL_W;
                    if (tap_in_img(oh, ow, t)) begin : g_img
                        assign tap_p[oh][ow][c][t] = bus.x_p[IH][IW][c];
                        assign tap_m[oh][ow][c][t] = bus.x_m[IH][IW][c];
                    end else begin : g_pad
                        assign tap_p[oh][ow][c][t] = 1'b0;
                        assign tap_m[oh][ow][c][t] = 1'b0;
                    end
                end
            end
        end
    end

    if (MODE == POOL_MAX) begin : g_max
        for (genvar oh = 0; oh < OUT_HEIGHT; oh++) begin : g_oh
            for (genvar ow = 0; ow < OUT_WIDTH; ow++) begin : g_ow
                for (genvar c = 0; c < CHANNELS; c++) begin : g_c
                    logic [K-1:0] pm;
                    for (genvar t = 0; t < K; t++) begin : g_pm
                        assign pm[t] = !tap_in_img(oh, ow, t);
                    end
                    stoch_signed_window_max #(.NUM_INPUTS(K), .COUNT_W(COUNT_W)) u_win (
                        .CLK      (CLK),
                        .nRST     (nRST),
                        .en       (bus.en),
                        .restart  (bus.restart),
                        .as_p     (tap_p[oh][ow][c]),
                        .as_m     (tap_m[oh][ow][c]),
                        .pad_mask (pm),
                        .y_p      (win_p[oh][ow][c]),
                        .y_m      (win_m[oh][ow][c])
                    );
                end
            end
        end
    end else begin : g_avg
        logic [SEL_W-1:0] sel_q, sel_d, sel_cur;

        // A restart this cycle selects as if sel had already been cleared.
        assign sel_cur = bus.restart ? '0 : sel_q;

        // Rotating tap pointer shared by all windows; advances only on qualified cycles.
        always_comb begin
            sel_d = sel_q;
            if (bus.en)
                sel_d = (sel_cur == SEL_W'(K - 1)) ? '0 : sel_cur + SEL_W'(1);
            else if (bus.restart)
                sel_d = '0;
        end

        // Tap pointer register.
        always_ff @(posedge CLK) begin
            if (!nRST) sel_q <= '0;
            else       sel_q <= sel_d;
        end

        for (genvar oh = 0; oh < OUT_HEIGHT; oh++) begin : g_oh
            for (genvar ow = 0; ow < OUT_WIDTH; ow++) begin : g_ow
                for (genvar c = 0; c < CHANNELS; c++) begin : g_c
                    assign win_p[oh][ow][c] = tap_p[oh][ow][c][sel_cur];
                    assign win_m[oh][ow][c] = tap_m[oh][ow][c][sel_cur];
                end
            end
        end
    end

    // Idle cycles emit zero bits so downstream stochastic ops see no stray ones.
    always_comb begin
        y_p_d     = bus.en ? win_p : '0;
        y_m_d     = bus.en ? win_m : '0;
        y_valid_d = bus.en;
    end

    // Output register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            y_p_q     <= '0;
            y_m_q     <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_p_q     <= y_p_d;
            y_m_q     <= y_m_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.y_p     = y_p_q;
    assign bus.y_m     = y_m_q;
    assign bus.y_valid = y_valid_q;
endmodule

// File: tb/tb_stoch_signed_pool.sv
// Bench for stoch_signed_pool: three 4x4x1 instances (2x2/s2 max, 2x2/s2 avg,
// 3x3/s1/p1 max) share one input stream and are compared every cycle against a
// window-by-window arithmetic model, plus directed spot checks.
module tb_stoch_signed_pool;
    import stoch_pool_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                 nrst, en, restart;
    logic [3:0][3:0][0:0] xp, xm;

    int checks = 0;
    int errors = 0;

    stoch_signed_pool_if #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .OUT_HEIGHT(2), .OUT_WIDTH(2)) if_max ();
    stoch_signed_pool_if #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .OUT_HEIGHT(2), .OUT_WIDTH(2)) if_avg ();
    stoch_signed_pool_if #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .OUT_HEIGHT(4), .OUT_WIDTH(4)) if_pad ();

    assign if_max.en = en;  assign if_max.restart = restart;  assign if_max.x_p = xp;  assign if_max.x_m = xm;
    assign if_avg.en = en;  assign if_avg.restart = restart;  assign if_avg.x_p = xp;  assign if_avg.x_m = xm;
    assign if_pad.en = en;  assign if_pad.restart = restart;  assign if_pad.x_p = xp;  assign if_pad.x_m = xm;

    stoch_signed_pool #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
        .PAD_H(0), .PAD_W(0), .STRIDE_H(2), .STRIDE_W(2), .MODE(POOL_MAX), .COUNT_W(4))
        dut_max (.CLK(CLK), .nRST(nrst), .bus(if_max));
    stoch_signed_pool #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
        .PAD_H(0), .PAD_W(0), .STRIDE_H(2), .STRIDE_W(2), .MODE(POOL_AVG), .COUNT_W(4))
        dut_avg (.CLK(CLK), .nRST(nrst), .bus(if_avg));
    stoch_signed_pool #(.IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(3), .KERNEL_W(3),
        .PAD_H(1), .PAD_W(1), .STRIDE_H(1), .STRIDE_W(1), .MODE(POOL_MAX), .COUNT_W(4))
        dut_pad (.CLK(CLK), .nRST(nrst), .bus(if_pad));

    // Model state: config 0 = max 2x2/s2, 1 = avg 2x2/s2, 2 = max 3x3/s1/p1.
    int cnt   [3][4][4][9];
    int sel_m [3];
    bit ep    [3][4][4];
    bit em    [3][4][4];
    bit ev    [3];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            int kk, st, pd, on, kn, s;
            kk = (c == 2) ? 3 : 2;
            st = (c == 2) ? 1 : 2;
            pd = (c == 2) ? 1 : 0;
            on = (c == 2) ? 4 : 2;
            kn = kk * kk;
            if (!nrst) begin
                sel_m[c] = 0;
                ev[c]    = 1'b0;
                for (int a = 0; a < 4; a++)
                    for (int b = 0; b < 4; b++) begin
                        ep[c][a][b] = 1'b0;
                        em[c][a][b] = 1'b0;
                        for (int t = 0; t < 9; t++) cnt[c][a][b][t] = 0;
                    end
            end else begin
                ev[c] = en;
                s = restart ? 0 : sel_m[c];
                for (int oh = 0; oh < on; oh++)
                    for (int ow = 0; ow < on; ow++) begin
                        int tp[9], tm[9], cur[9];
                        bit tpad[9];
                        int best;
                        for (int t = 0; t < kn; t++) begin
                            int ih, iw;
                            ih = oh * st - pd + t / kk;
                            iw = ow * st - pd + t % kk;
                            if (ih >= 0 && ih < 4 && iw >= 0 && iw < 4) begin
                                tp[t] = int'(xp[ih][iw][0]);
                                tm[t] = int'(xm[ih][iw][0]);
                                tpad[t] = 1'b0;
                            end else begin
                                tp[t] = 0;
                                tm[t] = 0;
                                tpad[t] = 1'b1;
                            end
                        end
                        if (c == 1) begin
                            best = s;
                        end else begin
                            for (int t = 0; t < kn; t++) cur[t] = restart ? 0 : cnt[c][oh][ow][t];
                            best = 0;
                            for (int t = 1; t < kn; t++) if (cur[t] > cur[best]) best = t;
                            for (int t = 0; t < kn; t++) begin
                                int v;
                                v = cur[t];
                                if (en && !tpad[t]) begin
                                    v = v + tp[t] - tm[t];
                                    if (v > 7)  v = 7;
                                    if (v < -7) v = -7;
                                end
                                cnt[c][oh][ow][t] = v;
                            end
                        end
                        ep[c][oh][ow] = en && (tp[best] != 0);
                        em[c][oh][ow] = en && (tm[best] != 0);
                    end
                if (c == 1) sel_m[c] = en ? (s + 1) % kn : s;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0][1:0][0:0] e0p, e0m, e1p, e1m;
        logic [3:0][3:0][0:0] e2p, e2m;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                e2p[a][b][0] = ep[2][a][b];
                e2m[a][b][0] = em[2][a][b];
                if (a < 2 && b < 2) begin
                    e0p[a][b][0] = ep[0][a][b];
                    e0m[a][b][0] = em[0][a][b];
                    e1p[a][b][0] = ep[1][a][b];
                    e1m[a][b][0] = em[1][a][b];
                end
            end
        chk("max_y_p", 16'(if_max.y_p), 16'(e0p));
        chk("max_y_m", 16'(if_max.y_m), 16'(e0m));
        chk("max_vld", 16'(if_max.y_valid), 16'(ev[0]));
        chk("avg_y_p", 16'(if_avg.y_p), 16'(e1p));
        chk("avg_y_m", 16'(if_avg.y_m), 16'(e1m));
        chk("avg_vld", 16'(if_avg.y_valid), 16'(ev[1]));
        chk("pad_y_p", 16'(if_pad.y_p), 16'(e2p));
        chk("pad_y_m", 16'(if_pad.y_m), 16'(e2m));
        chk("pad_vld", 16'(if_pad.y_valid), 16'(ev[2]));
    endtask

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic clear_stream();
        restart = 1'b1;
        en      = 1'b0;
        xp      = '0;
        xm      = '0;
        step();
        chk("restart_idle_vld", 16'(if_max.y_valid), 16'd0);
        restart = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; restart = 1'b0; xp = '1; xm = '0;

        // Reset dominates en with all-ones input.
        repeat (3) begin
            step();
            chk("rst_max_y_p", 16'(if_max.y_p), 16'd0);
            chk("rst_vld", 16'(if_max.y_valid), 16'd0);
        end
        nrst = 1'b1; xp = '0;
        step();
        chk("first_vld", 16'(if_max.y_valid), 16'd1);

        // Max select: tap 3 of window (0,0) carries +1.
        clear_stream();
        en = 1'b1; xp[1][1][0] = 1'b1;
        step();
        chk("max_tie_first", 16'(if_max.y_p), 16'd0);
        repeat (3) step();
        chk("max_sel_tap3", 16'(if_max.y_p), 16'h1);
        chk("max_sel_m", 16'(if_max.y_m), 16'h0);

        // Saturation at +7, decay to zero, then hand over to tap 1 (p=m=1).
        clear_stream();
        en = 1'b1;
        xp[0][0][0] = 1'b1; xp[0][1][0] = 1'b1; xm[0][1][0] = 1'b1;
        repeat (20) step();
        chk("sat_up_sel", 16'(if_max.y_p[0][0][0]), 16'd1);
        xp[0][0][0] = 1'b0; xm[0][0][0] = 1'b1;
        repeat (7) step();
        chk("sat_down_p", 16'(if_max.y_p[0][0][0]), 16'd0);
        chk("sat_down_m", 16'(if_max.y_m[0][0][0]), 16'd1);
        step();
        chk("sat_tie0_m", 16'(if_max.y_m[0][0][0]), 16'd1);
        chk("sat_tie0_p", 16'(if_max.y_p[0][0][0]), 16'd0);
        step();
        chk("sat_switch_p", 16'(if_max.y_p[0][0][0]), 16'd1);
        chk("sat_switch_m", 16'(if_max.y_m[0][0][0]), 16'd1);

        // Average mode rotation with an en gap.
        clear_stream();
        en = 1'b1; xp[0][0][0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("avg_phase", 16'(if_avg.y_p[0][0][0]), 16'((i % 4) == 0));
        end
        en = 1'b0;
        repeat (2) begin
            step();
            chk("avg_gap_vld", 16'(if_avg.y_valid), 16'd0);
            chk("avg_gap_y", 16'(if_avg.y_p), 16'd0);
        end
        en = 1'b1;
        for (int i = 6; i < 9; i++) begin
            step();
            chk("avg_resume", 16'(if_avg.y_p[0][0][0]), 16'((i % 4) == 0));
        end

        // Padding: all taps -1, so the corner locks onto a zero pad tap.
        clear_stream();
        en = 1'b1; xm = '1;
        repeat (4) step();
        chk("pad_corner_p", 16'(if_pad.y_p[0][0][0]), 16'd0);
        chk("pad_corner_m", 16'(if_pad.y_m[0][0][0]), 16'd0);
        chk("pad_inner_m", 16'(if_pad.y_m[1][1][0]), 16'd1);

        // Restart with en while tap 2 leads.
        clear_stream();
        en = 1'b1; xp[1][0][0] = 1'b1;
        repeat (5) step();
        chk("lead_tap2", 16'(if_max.y_p[0][0][0]), 16'd1);
        restart = 1'b1; xm[0][0][0] = 1'b1;
        step();
        chk("rst_en_tap0_m", 16'(if_max.y_m[0][0][0]), 16'd1);
        chk("rst_en_tap0_p", 16'(if_max.y_p[0][0][0]), 16'd0);
        restart = 1'b0;
        step();
        chk("reconv_tap2", 16'(if_max.y_p[0][0][0]), 16'd1);
        chk("reconv_tap2_m", 16'(if_max.y_m[0][0][0]), 16'd0);

        // Random traffic; second half uses sparse m bits to drive estimators to the rails.
        for (int i = 0; i < 300; i++) begin
            nrst    = ($urandom_range(99) != 0);
            en      = ($urandom_range(9) < 8);
            restart = ($urandom_range(19) == 0);
            xp      = 16'($urandom);
            xm      = (i < 150) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
